eroder: RTL and testbench
=========================

# eroder

Streaming binary morphological erosion for the motion-segmentation pipeline; the dual of the dilator. It consumes a 1-bit mask in raster order, keyed by the shared `hpos`/`vpos` timing counters. It emits the eroded mask, delayed by R = WIN_SIZE/2 lines plus R pixels, together with the output coordinates. It typically precedes the dilator (erode-then-dilate opening) to remove speckle from the foreground mask.

## Interface
- `H_IMG_RES`, 640: active pixels per line.
- `V_IMG_RES`, 480: active lines per frame.
- `H_TOTAL`, 800: hpos period including blanking; must be ≥ H_IMG_RES+R.
- `V_TOTAL`, 525: vpos period including blanking; must be ≥ V_IMG_RES+R.
- `WIN_SIZE`, 5: odd window size, 3..7; R = WIN_SIZE/2.
- `STRUCT_ELM`, 25'b01110_11111_11111_11111_01110: structuring element.
  - Bit index = WIN_SIZE·row + col.
  - Row 0 / col 0 = top/left tap.
- `BORDER_VAL`, 1'b0: value substituted for window taps outside the image.
- `clk` in 1: pixel clock, single clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `hpos` in 11: current horizontal timing count, 0..H_TOTAL-1.
- `vpos` in 11: current vertical timing count, 0..V_TOTAL-1.
- `in_pix` in 1: mask pixel at (hpos,vpos); ignored outside the active area.
- `out_pix` out 1: eroded pixel at (out_hpos,out_vpos); 0 when `out_valid`=0.
- `out_valid` out 1: output coordinate lies inside the active area.
- `out_hpos` out 11: registered output x coordinate.
- `out_vpos` out 11: registered output y coordinate.

## Operation
- Active input: `hpos`<H_IMG_RES and `vpos`<V_IMG_RES. Only active pixels are written to line storage.
- Line storage: WIN_SIZE-1 one-bit line RAMs (H_IMG_RES deep) in a ring.
  - `wr_line` counter (ceil_log2(WIN_SIZE-1) bits) advances at `hpos`=H_IMG_RES-1 on active lines.
  - `wr_line` wraps WIN_SIZE-2 → 0.
  - `wr_line` clears at `vpos`=0, `hpos`=0 so each frame starts at line 0.
- Window: WIN_SIZE×WIN_SIZE shift-register array.
  - Each cycle, column hpos is shifted in: the live pixel plus the WIN_SIZE-1 stored lines, ordered oldest→top.
  - Column fetch reads RAM address `hpos` (combinational or 1-cycle registered, compensated internally).
- Center coordinate: cx = hpos−R, cy = vpos−R, each modulo H_TOTAL / V_TOTAL.
- Tap (cx+dx, cy+dy), dx,dy ∈ [−R,R]: replaced by BORDER_VAL if the coordinate falls outside 0..H_IMG_RES-1 / 0..V_IMG_RES-1. This covers blanking, row/column wrap and stale RAM contents.
- Result = AND over taps with STRUCT_ELM bit set, i.e. &(~STRUCT_ELM | masked_window). With STRUCT_ELM all-zero the result is 1.
- `out_valid` = (cx<H_IMG_RES && cy<V_IMG_RES). `out_pix` = result & `out_valid`.
- R trailing lines/pixels are emitted during blanking, which is why H_TOTAL/V_TOTAL ≥ IMG_RES+R.
- No stall or backpressure; `hpos`/`vpos` are free-running and trusted.

## Timing
- All outputs registered; one pipeline stage after the window.
- Outputs for center (cx,cy) appear on the cycle after input (cx+R, cy+R) is sampled.
- Reset values:
  - `out_pix`=0, `out_valid`=0, `out_hpos`=0, `out_vpos`=0.
  - `wr_line`=0, window registers 0.
  - Line RAMs are not reset.
- Reset mid-frame: outputs go to 0 immediately. After release, the first correct frame is the next frame starting at `vpos`=0, `hpos`=0.
  - Remainder of the current frame may be wrong, but stays `out_valid`-consistent.
  - Stale RAM data is never used at cy<R, because those taps are border-masked.
- Frame wrap: vpos V_TOTAL−1→0 during blanking. Bottom-row output (cy=V_IMG_RES−1) occurs at vpos=V_IMG_RES−1+R, which is still before wrap.
- Line wrap: rightmost column output (cx=H_IMG_RES−1) at hpos=H_IMG_RES−1+R, within horizontal blanking.

## Structure
- `ceil_log2` and the window/coordinate helper functions go in the shared header `verilog_utils.vh`.
- The default STRUCT_ELM constant also goes there, so dilator and eroder share the same element.
- One sub-module: `bin_line_ram`, a 1-bit × H_IMG_RES simple dual-port RAM with write enable and synchronous read, inferring block RAM. It is instantiated WIN_SIZE-1 times.
- Window, border mask and AND reduction stay in `eroder`.

## Test plan
Bench parameters: H_IMG_RES=16, V_IMG_RES=12, H_TOTAL=20, V_TOTAL=16, WIN_SIZE=3, STRUCT_ELM=9'b111111111.
1. All-ones frame, BORDER_VAL=0 → `out_pix`=1 exactly for cx∈1..14, cy∈1..10. The 1-pixel border ring is 0. `out_valid` count = 192 per frame.
2. All-ones frame, BORDER_VAL=1 → all 192 valid outputs = 1.
3. Solid 3×3 block at (5..7, 4..6) → only (6,5)=1. Isolated single pixel at (10,8) → removed (all 0).
4. Latency check: center (6,5) reported with `out_hpos`=6, `out_vpos`=5 on the cycle after input (7,6).
5. Assert `rst_n`=0 at vpos=6 for 3 cycles, then repeat test 1 → outputs 0 during reset; next frame matches test 1 bit-exactly.
6. Cross shape STRUCT_ELM=9'b010111010; frame containing a plus centered at (8,6) → `out_pix`=1 only at (8,6).

Source files
------------

// File: rtl/eroder_pkg.sv
// Shared constants and helpers for the binary morphology blocks (eroder/dilator).
// Holds the default structuring element and the window/coordinate arithmetic.
package eroder_pkg;

  localparam logic [24:0] DEFAULT_STRUCT_ELM = 25'b01110_11111_11111_11111_01110;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Window center lags the timing counter by r, wrapping modulo the counter period.
  function automatic logic [10:0] center_coord(input logic [10:0] pos, input int r,
                                               input int total);
    int v;
    v = int'(pos) - r;
    if (v < 0) v = v + total;
    return 11'(v);
  endfunction

  function automatic logic tap_inside(input logic [10:0] c, input int d, input int lim);
    int v;
    v = int'(c) + d;
    return (v >= 0) && (v < lim);
  endfunction

endpackage

// File: rtl/eroder_bin_line_ram.sv
// One-bit simple dual-port line buffer with synchronous read; maps onto block RAM.
module bin_line_ram
  import eroder_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = ceil_log2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic mem_q [DEPTH];
  logic rdata_q;

  // NOTE: storage and read register carry no reset so the array infers block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eroder.sv
// Streaming binary erosion over a WIN_SIZE x WIN_SIZE window built from a line-RAM ring.
// Output for center (cx,cy) is registered on the edge that samples input (cx+R,cy+R).
module eroder
  import eroder_pkg::*;
#(
  parameter int H_IMG_RES = 640,
  parameter int V_IMG_RES = 480,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525,
  parameter int WIN_SIZE  = 5,
  parameter logic [WIN_SIZE*WIN_SIZE-1:0] STRUCT_ELM = DEFAULT_STRUCT_ELM,
  parameter logic BORDER_VAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        in_pix,
  output logic        out_pix,
  output logic        out_valid,
  output logic [10:0] out_hpos,
  output logic [10:0] out_vpos
);

  localparam int R  = WIN_SIZE / 2;
  localparam int NL = WIN_SIZE - 1;
  localparam int LW = ceil_log2(NL);
  localparam int AW = ceil_log2(H_IMG_RES);
  localparam logic [10:0] H_ACT  = 11'(H_IMG_RES);
  localparam logic [10:0] V_ACT  = 11'(V_IMG_RES);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(NL - 1);

  logic          active;
  logic [LW-1:0] wr_line_q, wr_line_d, wr_sel;
  logic [10:0]   next_h;
  logic [AW-1:0] raddr;
  logic [NL-1:0] rd;
  logic [WIN_SIZE-1:0] col;
  logic [WIN_SIZE-1:0] win_q [NL];
  logic [WIN_SIZE-1:0] win   [WIN_SIZE];
  logic [10:0]   cx, cy;
  logic          valid, result;
  logic          out_pix_q, out_valid_q;
  logic [10:0]   out_hpos_q, out_vpos_q;

  assign active = (hpos < H_ACT) && (vpos < V_ACT);
  // Frame start forces line 0 combinationally so pixel (0,0) lands in the same RAM as its line.
  assign wr_sel = (hpos == '0 && vpos == '0) ? '0 : wr_line_q;

  always_comb begin
    wr_line_d = wr_sel;
    if (active && hpos == H_ACT - 11'd1) wr_line_d = (wr_sel == LINE_LAST) ? '0 : wr_sel + 1'b1;
  end

  // Synchronous RAM read is issued one pixel ahead so data aligns with the live pixel.
  assign next_h = (hpos == H_LAST) ? '0 : hpos + 11'd1;
  assign raddr  = (next_h < H_ACT) ? next_h[AW-1:0] : '0;

  for (genvar i = 0; i < NL; i++) begin : g_line
    bin_line_ram #(.DEPTH(H_IMG_RES), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (active && wr_sel == LW'(i)),
      .waddr_i (hpos[AW-1:0]),
      .wdata_i (in_pix),
      .raddr_i (raddr),
      .rdata_o (rd[i])
    );
  end

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    int idx;
    col = '0;
    col[WIN_SIZE-1] = in_pix;
    for (int k = 0; k < NL; k++) begin
      idx = int'(wr_sel) + k;
      if (idx >= NL) idx = idx - NL;
      col[k] = rd[idx];
    end
    for (int c = 0; c < WIN_SIZE; c++) win[c] = (c < NL) ? win_q[c] : col;
  end

  assign cx = center_coord(hpos, R, H_TOTAL);
  assign cy = center_coord(vpos, R, V_TOTAL);
  assign valid = (cx < H_ACT) && (cy < V_ACT);

  always_comb begin
    logic tap;
    result = 1'b1;
    for (int r = 0; r < WIN_SIZE; r++) begin
      for (int c = 0; c < WIN_SIZE; c++) begin
        tap = (tap_inside(cx, c - R, H_IMG_RES) && tap_inside(cy, r - R, V_IMG_RES))
              ? win[c][r] : BORDER_VAL;
        if (STRUCT_ELM[WIN_SIZE*r + c]) result = result & tap;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_line_q   <= '0;
      for (int c = 0; c < NL; c++) win_q[c] <= '0;
      out_pix_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_hpos_q  <= '0;
      out_vpos_q  <= '0;
    end else begin
      wr_line_q <= wr_line_d;
      for (int c = 0; c < NL; c++) win_q[c] <= win[c+1];
      out_pix_q   <= result & valid;
      out_valid_q <= valid;
      out_hpos_q  <= cx;
      out_vpos_q  <= cy;
    end
  end

  assign out_pix   = out_pix_q;
  assign out_valid = out_valid_q;
  assign out_hpos  = out_hpos_q;
  assign out_vpos  = out_vpos_q;

endmodule

// File: tb/tb_eroder.sv
// Self-checking bench: three eroder variants against a frame-level erosion model.
module tb_eroder;

  localparam int H = 16, V = 12, HT = 20, VT = 16, W = 3;
  localparam logic [8:0] SE_FULL  = 9'b111111111;
  localparam logic [8:0] SE_CROSS = 9'b010111010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hpos, vpos;
  logic        in_pix;
  logic [2:0]  o_pix, o_val;
  logic [10:0] o_h [3];
  logic [10:0] o_v [3];

  int checks = 0;
  int failures = 0;
  int vcnt [3];
  int ones [3];
  logic img [V][H];

  always #5 clk = ~clk;

  eroder #(.H_IMG_RES(H), .V_IMG_RES(V), .H_TOTAL(HT), .V_TOTAL(VT), .WIN_SIZE(W),
           .STRUCT_ELM(SE_FULL), .BORDER_VAL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .in_pix(in_pix),
    .out_pix(o_pix[0]), .out_valid(o_val[0]), .out_hpos(o_h[0]), .out_vpos(o_v[0]));

  eroder #(.H_IMG_RES(H), .V_IMG_RES(V), .H_TOTAL(HT), .V_TOTAL(VT), .WIN_SIZE(W),
           .STRUCT_ELM(SE_FULL), .BORDER_VAL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .in_pix(in_pix),
    .out_pix(o_pix[1]), .out_valid(o_val[1]), .out_hpos(o_h[1]), .out_vpos(o_v[1]));

  eroder #(.H_IMG_RES(H), .V_IMG_RES(V), .H_TOTAL(HT), .V_TOTAL(VT), .WIN_SIZE(W),
           .STRUCT_ELM(SE_CROSS), .BORDER_VAL(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .in_pix(in_pix),
    .out_pix(o_pix[2]), .out_valid(o_val[2]), .out_hpos(o_h[2]), .out_vpos(o_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Erosion straight from the definition: every selected neighbour must be set.
  function automatic logic model_pix(input int cx, input int cy, input logic border,
                                     input logic [8:0] se);
    logic res;
    int x, y;
    if (cx >= H || cy >= V) return 1'b0;
    res = 1'b1;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (se[3*(dy+1) + (dx+1)]) begin
          x = cx + dx;
          y = cy + dy;
          if (x >= 0 && x < H && y >= 0 && y < V) res = res & img[y][x];
          else res = res & border;
        end
    return res;
  endfunction

  task automatic fill(input int kind);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        case (kind)
          0: img[y][x] = 1'b1;
          1: img[y][x] = (x >= 5 && x <= 7 && y >= 4 && y <= 6) || (x == 10 && y == 8);
          2: img[y][x] = (x == 8 && y >= 5 && y <= 7) || (y == 6 && x >= 7 && x <= 9);
          default: img[y][x] = ($urandom_range(0, 3) != 0);
        endcase
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      check({tag, "_pix"}, 32'(o_pix[d]), 32'd0);
      check({tag, "_val"}, 32'(o_val[d]), 32'd0);
      check({tag, "_h"}, 32'(o_h[d]), 32'd0);
      check({tag, "_v"}, 32'(o_v[d]), 32'd0);
    end
  endtask

  task automatic run_frame(input bit do_reset, input bit probe_center);
    logic exp_pix [3];
    bit en;
    int cx, cy;
    en = 1'b1;
    for (int d = 0; d < 3; d++) begin vcnt[d] = 0; ones[d] = 0; end
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        hpos   = 11'(h);
        vpos   = 11'(v);
        in_pix = (h < H && v < V) ? img[v][h] : 1'($urandom);
        if (do_reset && v == 6 && h == 0) begin
          rst_n = 1'b0;
          en = 1'b0;
          #1;
          check_zero("rst_async");
        end
        if (do_reset && v == 6 && h == 3) rst_n = 1'b1;
        cx = (h - 1 + HT) % HT;
        cy = (v - 1 + VT) % VT;
        exp_pix[0] = model_pix(cx, cy, 1'b0, SE_FULL);
        exp_pix[1] = model_pix(cx, cy, 1'b1, SE_FULL);
        exp_pix[2] = model_pix(cx, cy, 1'b0, SE_CROSS);
        @(posedge clk);
        #1;
        if (!rst_n) check_zero("rst_hold");
        else if (en) begin
          for (int d = 0; d < 3; d++) begin
            check("pix", 32'(o_pix[d]), 32'(exp_pix[d]));
            check("val", 32'(o_val[d]), 32'(cx < H && cy < V));
            check("hpos", 32'(o_h[d]), 32'(cx));
            check("vpos", 32'(o_v[d]), 32'(cy));
            vcnt[d] += int'(o_val[d]);
            ones[d] += int'(o_pix[d]);
          end
          if (probe_center && h == 7 && v == 6) begin
            check("lat_hpos", 32'(o_h[0]), 32'd6);
            check("lat_vpos", 32'(o_v[0]), 32'd5);
            check("lat_pix", 32'(o_pix[0]), 32'd1);
          end
        end
      end
    end
  endtask

  task automatic check_counts(input string tag, input int a, input int b, input int c);
    for (int d = 0; d < 3; d++) check({tag, "_valid_cnt"}, 32'(vcnt[d]), 32'd192);
    check({tag, "_ones_a"}, 32'(ones[0]), 32'(a));
    check({tag, "_ones_b"}, 32'(ones[1]), 32'(b));
    check({tag, "_ones_c"}, 32'(ones[2]), 32'(c));
  endtask

  initial begin
    rst_n  = 1'b0;
    hpos   = '0;
    vpos   = '0;
    in_pix = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    fill(0);
    run_frame(1'b0, 1'b0);
    check_counts("ones", 140, 192, 140);

    fill(1);
    run_frame(1'b0, 1'b1);
    check_counts("block", 1, 1, 1);

    fill(0);
    run_frame(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);
    check_counts("post_rst", 140, 192, 140);

    fill(2);
    run_frame(1'b0, 1'b0);
    check_counts("plus", 0, 0, 1);

    for (int f = 0; f < 3; f++) begin
      fill(3);
      run_frame(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
